chicken_turn_ctrl: RTL
======================

// Module: chicken_turn_ctrl
// PURPOSE
//  Multi-player turn/game sequencer for the ChickenCHACHACHA board. Generalises the single-track
//  game control FSM to NUM_PLAYERS players: it tracks per-player track positions and rotates turns
//  on a miss. It declares the winner internally when a position reaches TRACK_LEN-1.
//  Sits between the key/card front-end (key, c, go) and the display/sound units (A, D, WR, M, pos).
// PARAMETERS
//  NUM_PLAYERS  2   players in rotation, 2..8
//  KEY_W        4   width of key code
//  SEL_MIN      2   lowest key code accepted as difficulty select
//  SEL_MAX      4   highest key code accepted as difficulty select
//  TRACK_LEN    12  track squares; a position of TRACK_LEN-1 wins
//  TIMEOUT_CYC  50000000  turn timeout in clk cycles (TURN_TIMEOUT_EN only)
// PORTS
//  clk        in   1                       system clock
//  rst        in   1                       async reset, active-high
//  key        in   KEY_W                   key code, 0 = no key
//  c          in   1                       continue/confirm level
//  go         in   1                       card match result, valid in JUDGE
//  A          out  1                       awaiting player key (high in TURN)
//  D          out  1                       one-cycle advance pulse
//  WR         out  1                       setup phase (high in IDLE, SELECT)
//  M          out  3                       current state code
//  level      out  KEY_W                   latched difficulty select
//  player     out  $clog2(NUM_PLAYERS)     current player
//  pos        out  NUM_PLAYERS*$clog2(TRACK_LEN)  packed positions, player 0 in LSBs
//  win_valid  out  1                       high in WIN
//  winner     out  $clog2(NUM_PLAYERS)     winning player, valid with win_valid
// BEHAVIOUR
//  - All outputs registered. On rst: M=IDLE, A=D=0, WR=1, level=0, player=0, all pos=0, win_valid=0, winner=0.
//  - Reset asserted in any state aborts the game immediately. No state survives.
//  - States, encoded in 3 bits:
//    IDLE 000     c=1 -> SELECT
//    SELECT 001   SEL_MIN<=key<=SEL_MAX -> latch level, ->WAITC; else stay
//    WAITC 010    c=1 -> TURN
//    TURN 011     key!=0 -> JUDGE; else stay
//    JUDGE 100    go=1 -> ADV; go=0 -> MISS
//    MISS 101     c=1 -> player=(player+1) mod NUM_PLAYERS, ->TURN
//    ADV 110      see advance rule below
//    WIN 111      terminal until rst
//  - Advance rule: on the JUDGE->ADV transition, D=1 for exactly that one following cycle. pos[player]
//    increments by 1 in that same cycle. In ADV: if the new pos==TRACK_LEN-1 -> WIN,
//    winner=player, win_valid=1. Otherwise -> TURN with the same player (the player keeps the turn).
//  - pos saturates at TRACK_LEN-1 and never wraps.
//  - player wraps NUM_PLAYERS-1 -> 0.
//  - A=1 on every cycle M==TURN, else 0. WR=1 on every cycle M is IDLE or SELECT, else 0.
//  - Inputs are sampled as levels, with no edge detection. If c is still high on entry to
//    WAITC or MISS, the FSM proceeds on the next cycle; debouncing is upstream.
//  - key and go are ignored outside SELECT/TURN and JUDGE respectively.
// CONFIGURATION
//  TURN_TIMEOUT_EN defined:
//    - A cycle counter runs in TURN and clears on TURN entry.
//    - When it reaches TIMEOUT_CYC-1 with key==0, the FSM moves to MISS, exactly as if go=0 with no D.
//    - A key!=0 on that same cycle takes priority (-> JUDGE).
//  TURN_TIMEOUT_EN undefined: no counter; TURN waits indefinitely.
// STRUCTURE
//  - Shared package chicken_pkg: state localparams ST_IDLE..ST_WIN (3-bit), and a function
//    for clog2-safe widths (minimum 1).
//  - One sub-module: chicken_turn_timer (load/enable/expire counter). It is instantiated only
//    under TURN_TIMEOUT_EN.
//  - The position array is held locally and packed onto pos.
// TESTING
//  1. rst mid-ADV with pos0=3 -> next cycle M=000, pos=0, D=0, WR=1.
//  2. IDLE c=1, key=1 then key=5 then key=3 -> stays SELECT for 1 and 5; level=3, M=010.
//  3. NUM_PLAYERS=3, player 2 in JUDGE go=0, then c=1 in MISS -> player=0, M=011, D never asserted.
//  4. TRACK_LEN=4, player 1 hits go=1 three times -> three single-cycle D pulses, pos1=3,
//     M=111, winner=1, win_valid=1. Further key/c/go inputs leave M at 111.
//  5. TURN_TIMEOUT_EN, TIMEOUT_CYC=8, key=0 in TURN -> MISS after 8 cycles.
//     With key=2 on cycle 8 -> JUDGE instead.

Source files
------------

// File: rtl/chicken_pkg.sv
// rtl/chicken_pkg.sv - shared state codes and width helper for the chicken turn controller
// Purpose: 3-bit state encoding shared by the turn controller and its bench-visible M output,
//          plus a $clog2 wrapper that never returns a zero width.
// Ports:   none (package)
package chicken_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_SELECT = 3'b001,
    ST_WAITC  = 3'b010,
    ST_TURN   = 3'b011,
    ST_JUDGE  = 3'b100,
    ST_MISS   = 3'b101,
    ST_ADV    = 3'b110,
    ST_WIN    = 3'b111
  } state_t;

  // Width of a field able to index n values; a one-value field still needs one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chicken_turn_timer.sv
// rtl/chicken_turn_timer.sv - turn timeout counter with load, enable and expire
// Purpose: counts enabled cycles since the last load; expire is high while enabled and the
//          count has reached TIMEOUT_CYC-1. Only used when TURN_TIMEOUT_EN is defined.
// Ports:   clk    in  system clock
//          rst    in  async reset, active-high
//          load   in  clear the count to zero
//          en     in  count this cycle
//          expire out count == TIMEOUT_CYC-1 while enabled
module chicken_turn_timer
  import chicken_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = safe_clog2(TIMEOUT_CYC);

  logic [CW-1:0] count;

  assign expire = en && (count == CW'(TIMEOUT_CYC - 1));

  // Holds at the terminal value so a stalled caller never sees the count wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/chicken_turn_ctrl.sv
// rtl/chicken_turn_ctrl.sv - multi-player turn/game sequencer for the ChickenCHACHACHA board
// Purpose: walks setup (IDLE, SELECT, WAITC), then rotates turns between NUM_PLAYERS players,
//          advancing a player's track position on a card match and declaring a winner when a
//          position reaches TRACK_LEN-1. Optional macro TURN_TIMEOUT_EN adds a per-turn timeout
//          that forces a miss after TIMEOUT_CYC idle cycles in TURN.
// Ports:   clk, rst (async, active-high)
//          key   in  key code, 0 = no key
//          c     in  continue/confirm level
//          go    in  card match result, used in JUDGE
//          A     out high while in TURN
//          D     out one-cycle advance pulse (the ADV cycle)
//          WR    out high in IDLE and SELECT
//          M     out current state code
//          level out latched difficulty select
//          player out current player
//          pos   out packed track positions, player 0 in the LSBs
//          win_valid out high in WIN
//          winner out winning player, valid with win_valid
module chicken_turn_ctrl
  import chicken_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int KEY_W       = 4,
  parameter int SEL_MIN     = 2,
  parameter int SEL_MAX     = 4,
  parameter int TRACK_LEN   = 12,
  parameter int TIMEOUT_CYC = 50000000,
  localparam int PW = safe_clog2(NUM_PLAYERS),
  localparam int TW = safe_clog2(TRACK_LEN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KEY_W-1:0]          key,
  input  logic                      c,
  input  logic                      go,
  output logic                      A,
  output logic                      D,
  output logic                      WR,
  output logic [2:0]                M,
  output logic [KEY_W-1:0]          level,
  output logic [PW-1:0]             player,
  output logic [NUM_PLAYERS*TW-1:0] pos,
  output logic                      win_valid,
  output logic [PW-1:0]             winner
);

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] pos_q [NUM_PLAYERS];
  logic [TW-1:0] cur_pos;
  logic          timer_expire;
  logic          key_in_range;

  localparam logic [TW-1:0] POS_LAST    = TW'(TRACK_LEN - 1);
  localparam logic [PW-1:0] PLAYER_LAST = PW'(NUM_PLAYERS - 1);

`ifdef TURN_TIMEOUT_EN
  // Held in load outside TURN, so the count is zero on every TURN entry.
  chicken_turn_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state_q != ST_TURN),
    .en     (state_q == ST_TURN),
    .expire (timer_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign timer_expire   = 1'b0;
`endif

  assign cur_pos      = pos_q[player];
  assign key_in_range = (key >= KEY_W'(SEL_MIN)) && (key <= KEY_W'(SEL_MAX));
  assign M            = state_q;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pack
    assign pos[p*TW +: TW] = pos_q[p];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (c) state_d = ST_SELECT;
      ST_SELECT: if (key_in_range) state_d = ST_WAITC;
      ST_WAITC:  if (c) state_d = ST_TURN;
      // A key pressed on the expiry cycle still wins over the timeout.
      ST_TURN: begin
        if (key != '0)        state_d = ST_JUDGE;
        else if (timer_expire) state_d = ST_MISS;
      end
      ST_JUDGE:  state_d = go ? ST_ADV : ST_MISS;
      ST_MISS:   if (c) state_d = ST_TURN;
      // pos already holds the incremented value in the ADV cycle.
      ST_ADV:    state_d = (cur_pos == POS_LAST) ? ST_WIN : ST_TURN;
      ST_WIN:    state_d = ST_WIN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      A         <= 1'b0;
      D         <= 1'b0;
      WR        <= 1'b1;
      level     <= '0;
      player    <= '0;
      win_valid <= 1'b0;
      winner    <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      A         <= (state_d == ST_TURN);
      WR        <= (state_d == ST_IDLE) || (state_d == ST_SELECT);
      D         <= (state_q == ST_JUDGE) && (state_d == ST_ADV);
      win_valid <= (state_d == ST_WIN);

      if (state_q == ST_SELECT && state_d == ST_WAITC) level <= key;

      if (state_q == ST_MISS && state_d == ST_TURN)
        player <= (player == PLAYER_LAST) ? '0 : player + 1'b1;

      // Saturate rather than wrap; a full track is only reachable on the final advance.
      if (state_q == ST_JUDGE && state_d == ST_ADV && cur_pos != POS_LAST)
        pos_q[player] <= cur_pos + 1'b1;

      if (state_q == ST_ADV && state_d == ST_WIN) winner <= player;
    end
  end

endmodule
